// File: rtl/uart_tx_sched.sv
// uart_tx_sched -- round-robin byte scheduler in front of a UART transmitter.
//
// Picks one of NREQ byte requesters per frame. The search starts at a
// rotating pointer. The chosen byte is handed to the transmitter with a
// start/done level handshake:
//   IDLE    : accept a winner (combinational one-hot req_ready), load d_tx
//   SEND    : hold tx_start/d_tx until tx_done is sampled high
//   RELEASE : wait for tx_done to fall so long stop phases drain fully
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   req_valid[NREQ]       per-requester byte available
//   req_data[8*NREQ]      requester i byte at [8i+7:8i]
//   req_ready[NREQ]       one-hot, one-cycle accept pulse (IDLE only)
//   tx_start, d_tx[8]     registered start level and byte to the transmitter
//   tx_done               transmitter stop-phase/done level
//   grant_id              index of last granted requester
//   busy                  high whenever not in IDLE
//   err_clr, err_timeout  sticky SEND timeout flag and its clear
//
// Optional feature: define UART_TX_SCHED_TIMEOUT_EN to abort a SEND after
// TIMEOUT cycles without tx_done. Without it, err_timeout is tied low and
// err_clr is ignored.
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 200000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    tx_start,
    output logic [7:0]              d_tx,
    input  logic                    tx_done,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    input  logic                    err_clr,
    output logic                    err_timeout
);
    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SEND    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]    r_state;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_grant_id;
    logic          r_tx_start;
    logic [7:0]    r_d_tx;

    logic          w_found;
    logic [IW-1:0] w_win;
    logic [7:0]    w_win_data;
    logic          w_accept;
    logic [IW-1:0] w_next_ptr;
    logic          w_abort;

    // Round-robin search split in two passes: indices at/above the pointer
    // first, then the wrapped-around ones below it. This works for any
    // NREQ, including non powers of two.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (IW'(i) >= r_rr_ptr)) begin
                w_found    = 1'b1;
                w_win      = IW'(i);
                w_win_data = req_data[8*i +: 8];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (IW'(i) < r_rr_ptr)) begin
                w_found    = 1'b1;
                w_win      = IW'(i);
                w_win_data = req_data[8*i +: 8];
            end
        end
    end

    // Reset gates the accept so no ready pulse can appear while reset is held.
    assign w_accept   = (r_state == S_IDLE) && w_found && !reset;
    assign w_next_ptr = (w_win == IW'(NREQ-1)) ? '0 : w_win + 1'b1;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_accept && (w_win == IW'(i));
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // The abort fires on the TIMEOUT-th SEND cycle, so tx_start is high for
    // exactly TIMEOUT cycles. A tx_done on that same cycle wins.
    assign w_abort = (r_state == S_SEND) && !tx_done && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if ((r_state == S_SEND) && !tx_done && !w_abort) r_cnt <= r_cnt + 1'b1;
            else                                             r_cnt <= '0;
            // A new timeout beats a simultaneous clear.
            if (w_abort)      r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    assign err_timeout = r_err;
`else
    logic w_unused;

    assign w_abort     = 1'b0;
    assign err_timeout = 1'b0;
    assign w_unused    = err_clr ^ (TIMEOUT == 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tx_start <= 1'b0;
            r_d_tx     <= 8'h00;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A stale tx_done level here is deliberately ignored.
                    if (w_accept) begin
                        r_d_tx     <= w_win_data;
                        r_grant_id <= w_win;
                        r_rr_ptr   <= w_next_ptr;
                        r_tx_start <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_done || w_abort) begin
                        r_tx_start <= 1'b0;
                        r_state    <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!tx_done) r_state <= S_IDLE;
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_start = r_tx_start;
    assign d_tx     = r_d_tx;
    assign grant_id = r_grant_id;
    assign busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0] req_ready;
    logic         tx_start;
    logic [7:0]   d_tx;
    logic         tx_done;
    logic [1:0]   grant_id;
    logic         busy;
    logic         err_clr;
    logic         err_timeout;

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;   // model: next requester to look at first

    always #5 clk = ~clk;

    uart_tx_sched #(.NREQ(N), .TIMEOUT(50)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .d_tx(d_tx), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy), .err_clr(err_clr), .err_timeout(err_timeout)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: first valid requester walking upward from m_ptr, modulo N.
    function automatic int pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One full frame. Called at posedge+1 with the DUT in IDLE.
    task automatic do_frame(input logic [N-1:0] v, input int dly, input int rel, input bit stale);
        int w;
        logic [7:0] exp_d;
        logic [N-1:0] exp_r;
        req_valid = v;
        tx_done   = stale;
        #1;
        w = pick(v);
        exp_r = '0;
        exp_r[w] = 1'b1;
        exp_d = req_data[8*w +: 8];
        checks++;
        if (req_ready !== exp_r || busy !== 1'b0) begin
            errors++;
            $display("FAIL accept_ready: ready=%b busy=%b want ready=%b busy=0", req_ready, busy, exp_r);
        end
        step();
        m_ptr = (w + 1) % N;
        checks++;
        if (tx_start !== 1'b1 || d_tx !== exp_d || grant_id !== 2'(w) || busy !== 1'b1) begin
            errors++;
            $display("FAIL grant: start=%b d_tx=%h gid=%0d busy=%b want 1 %h %0d 1",
                     tx_start, d_tx, grant_id, busy, exp_d, w);
        end
        tx_done = 1'b0;
        req_valid = N'($urandom);
        #1;
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL send_ready: ready=%b want 0", req_ready);
        end
        for (int i = 0; i < dly; i++) begin
            step();
            checks++;
            if (tx_start !== 1'b1 || d_tx !== exp_d || busy !== 1'b1) begin
                errors++;
                $display("FAIL send_hold: start=%b d_tx=%h busy=%b want 1 %h 1", tx_start, d_tx, busy, exp_d);
            end
            req_valid = N'($urandom);
            #1;
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL send_ready: ready=%b want 0", req_ready);
            end
        end
        tx_done = 1'b1;
        step();
        checks++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_edge: start=%b busy=%b want 0 1", tx_start, busy);
        end
        for (int i = 0; i < rel; i++) begin
            req_valid = N'($urandom) | 4'b0001;
            #1;
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL release_ready: ready=%b want 0", req_ready);
            end
            step();
            checks++;
            if (tx_start !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL release_hold: start=%b busy=%b want 0 1", tx_start, busy);
            end
        end
        tx_done = 1'b0;
        req_valid = '0;
        step();
        checks++;
        if (tx_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL back_idle: start=%b busy=%b want 0 0", tx_start, busy);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_valid = '1;
        tx_done = 1'b0;
        err_clr = 1'b0;
        req_data = $urandom;
        step();
        step();
        reset = 1'b0;
        req_valid = '0;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '1;
        tx_done = 1'b0;
        err_clr = 1'b0;
        req_data = 32'h1122_3344;
        step();
        checks++;
        if (tx_start !== 1'b0 || d_tx !== 8'h00 || grant_id !== 2'd0 || busy !== 1'b0 ||
            err_timeout !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_state: start=%b d_tx=%h gid=%0d busy=%b err=%b ready=%b want 0 00 0 0 0 0000",
                     tx_start, d_tx, grant_id, busy, err_timeout, req_ready);
        end
        step();
        reset = 1'b0;
        req_valid = '0;
        m_ptr = 0;
    endtask

    task automatic test_single();
        req_data = $urandom;
        req_data[23:16] = 8'hA5;
        do_frame(4'b0100, 10, 0, 1'b0);
        checks++;
        if (grant_id !== 2'd2 || d_tx !== 8'hA5) begin
            errors++;
            $display("FAIL single: gid=%0d d_tx=%h want 2 a5", grant_id, d_tx);
        end
    endtask

    task automatic test_all_valid();
        apply_reset();
        for (int f = 0; f < 8; f++) begin
            req_data = $urandom;
            do_frame(4'b1111, 1, 0, 1'b0);
            checks++;
            if (grant_id !== 2'(f % 4)) begin
                errors++;
                $display("FAIL rr_order: frame %0d gid=%0d want %0d", f, grant_id, f % 4);
            end
        end
    endtask

    task automatic test_drain();
        req_data = $urandom;
        do_frame(4'b1010, 2, 16, 1'b0);
        req_data = $urandom;
        do_frame(4'b1111, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_send();
        req_data = $urandom;
        req_valid = 4'b1111;
        #1;
        step();
        for (int i = 0; i < 4; i++) step();
        req_valid = 4'b1111;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (tx_start !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || d_tx !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_send: start=%b busy=%b ready=%b d_tx=%h want 0 0 0000 00",
                     tx_start, busy, req_ready, d_tx);
        end
        step();
        checks++;
        if (req_ready !== '0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b start=%b want 0000 0", req_ready, tx_start);
        end
        reset = 1'b0;
        m_ptr = 0;
        req_data = $urandom;
        do_frame(4'b1111, 3, 1, 1'b0);
        checks++;
        if (grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_rr_ptr: gid=%0d want 0", grant_id);
        end
    endtask

    task automatic test_stale_done();
        req_data = $urandom;
        do_frame(4'b0001, 4, 2, 1'b1);
        checks++;
        if (grant_id !== 2'd0) begin
            errors++;
            $display("FAIL stale_done: gid=%0d want 0", grant_id);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        for (int it = 0; it < 40; it++) begin
            v = N'($urandom_range(0, 15));
            req_data = $urandom;
            if (v == '0) begin
                req_valid = '0;
                #1;
                checks++;
                if (req_ready !== '0) begin
                    errors++;
                    $display("FAIL idle_ready: ready=%b want 0000", req_ready);
                end
                step();
                checks++;
                if (tx_start !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_stay: start=%b busy=%b want 0 0", tx_start, busy);
                end
            end else begin
                do_frame(v, $urandom_range(0, 6), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic test_timeout();
        int cnt;
        req_data = $urandom;
        req_valid = 4'b0010;
        tx_done = 1'b0;
        #1;
        void'(pick(4'b0010));
        step();
        m_ptr = 2;
        req_valid = '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cnt = 0;
        while (tx_start === 1'b1 && cnt < 200) begin
            cnt++;
            step();
        end
        checks++;
        if (cnt !== 50 || err_timeout !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_abort: cycles=%0d err=%b busy=%b want 50 1 1", cnt, err_timeout, busy);
        end
        step();
        step();
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b busy=%b want 1 0", err_timeout, busy);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: err=%b want 0", err_timeout);
        end
        // Second abort with err_clr held: the new timeout must win.
        req_valid = 4'b0001;
        #1;
        step();
        m_ptr = 1;
        req_valid = '0;
        err_clr = 1'b1;
        cnt = 0;
        while (tx_start === 1'b1 && cnt < 200) begin
            cnt++;
            step();
        end
        checks++;
        if (cnt !== 50 || err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_vs_clear: cycles=%0d err=%b want 50 1", cnt, err_timeout);
        end
        step();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL clear_after: err=%b want 0", err_timeout);
        end
        err_clr = 1'b0;
`else
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            err_clr = 1'($urandom);
            step();
            if (tx_start === 1'b1 && err_timeout === 1'b0 && busy === 1'b1) cnt++;
        end
        err_clr = 1'b0;
        checks++;
        if (cnt !== 80) begin
            errors++;
            $display("FAIL no_timeout: good_cycles=%0d want 80", cnt);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout_end: busy=%b start=%b err=%b want 0 0 0", busy, tx_start, err_timeout);
        end
`endif
        req_data = $urandom;
        do_frame(4'b1111, 1, 1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        tx_done = 1'b0;
        err_clr = 1'b0;
        test_reset();
        test_single();
        test_all_valid();
        test_drain();
        test_reset_mid_send();
        test_stale_done();
        test_random();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
